// File: rtl/pic_bus_irr_isr.sv
// pic_bus_irr_isr
//   CPU bus front end plus interrupt request / in-service registers for a
//   small 8259-style interrupt controller.
//
//   Bus side: a write is "active" while chip_select_n and write_enable_n are
//   both low. The data byte and A0 are captured on every active cycle. When
//   the write ends, exactly one command-word pulse is raised for one cycle,
//   decoded from the captured byte and A0.
//
//   Interrupt side: the IRR latches IR edges or follows IR levels, with
//   per-bit clear. The ISR collects acknowledged bits and drops its
//   highest-priority bit on a non-specific EOI. An ICW1 pulse wipes both
//   registers and the edge history.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   chip_select_n, read_enable_n,
//   write_enable_n, A0, data_bus_in  CPU bus
//   sensitivity_mode                 1 = level IRR, 0 = edge IRR
//   peripheral_interrupts            IR7..IR0
//   clear_interrupt_request          per-bit IRR clear
//   int_no                           ISR bits to set
//   eoi                              non-specific end of interrupt
//   internal_data_bus                last written byte
//   write_*_command_word_*           one-cycle decode pulses
//   read                             combinational read select
//   interrupt_request, isr           IRR and ISR contents

module pic_bus_irr_isr (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       chip_select_n,
   input  logic       read_enable_n,
   input  logic       write_enable_n,
   input  logic       A0,
   input  logic [7:0] data_bus_in,
   input  logic       sensitivity_mode,
   input  logic [7:0] peripheral_interrupts,
   input  logic [7:0] clear_interrupt_request,
   input  logic [7:0] int_no,
   input  logic       eoi,
   output logic [7:0] internal_data_bus,
   output logic       write_initial_command_word_1,
   output logic       write_operation_control_word_1,
   output logic       write_operation_control_word_2,
   output logic       write_operation_control_word_3,
   output logic       read,
   output logic [7:0] interrupt_request,
   output logic [7:0] isr
);

   logic       w_write_active;
   logic       w_write_start;
   logic       w_write_event;
   logic       r_write_prev;
   logic       r_bus_idle;
   logic       r_write_armed;
   logic       r_a0;
   logic [7:0] r_data;
   logic       r_icw1;
   logic       r_ocw1;
   logic       r_ocw2;
   logic       r_ocw3;

   logic [7:0] r_ir_prev;
   logic [7:0] r_irr;
   logic [7:0] r_isr;
   logic [7:0] w_ir_rise;
   logic [7:0] w_irr_next;
   logic [7:0] w_eoi_mask;
   logic [7:0] w_isr_next;

   assign w_write_active = ~chip_select_n & ~write_enable_n;

   // r_bus_idle comes out of reset low, so a write that was already in
   // progress when reset was released never arms and never decodes.
   assign w_write_start = w_write_active & r_bus_idle;
   assign w_write_event = r_write_prev & ~w_write_active & r_write_armed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write_prev  <= 1'b0;
         r_bus_idle    <= 1'b0;
         r_write_armed <= 1'b0;
         r_a0          <= 1'b0;
         r_data        <= 8'h00;
         r_icw1        <= 1'b0;
         r_ocw1        <= 1'b0;
         r_ocw2        <= 1'b0;
         r_ocw3        <= 1'b0;
      end else begin
         r_write_prev <= w_write_active;
         r_bus_idle   <= ~w_write_active;
         if (w_write_active) begin
            r_data <= data_bus_in;
            r_a0   <= A0;
         end
         if (w_write_event) begin
            r_write_armed <= 1'b0;
         end else if (w_write_start) begin
            r_write_armed <= 1'b1;
         end
         // D[4] wins over D[3], so D[4:3]=11 with A0=0 is an ICW1 only.
         r_icw1 <= w_write_event & ~r_a0 & r_data[4];
         r_ocw1 <= w_write_event & r_a0;
         r_ocw2 <= w_write_event & ~r_a0 & (r_data[4:3] == 2'b00);
         r_ocw3 <= w_write_event & ~r_a0 & (r_data[4:3] == 2'b01);
      end
   end

   assign w_ir_rise  = peripheral_interrupts & ~r_ir_prev;
   assign w_irr_next = (sensitivity_mode ? peripheral_interrupts : (r_irr | w_ir_rise))
                       & ~clear_interrupt_request;

   // Two's-complement trick isolates the lowest set bit (highest priority).
   assign w_eoi_mask = eoi ? (r_isr & (~r_isr + 8'd1)) : 8'h00;
   assign w_isr_next = (r_isr & ~w_eoi_mask) | int_no;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ir_prev <= 8'hFF;
         r_irr     <= 8'h00;
         r_isr     <= 8'h00;
      end else if (r_icw1) begin
         // History to all ones: lines already high are not seen as new edges.
         r_ir_prev <= 8'hFF;
         r_irr     <= 8'h00;
         r_isr     <= 8'h00;
      end else begin
         r_ir_prev <= peripheral_interrupts;
         r_irr     <= w_irr_next;
         r_isr     <= w_isr_next;
      end
   end

   assign internal_data_bus              = r_data;
   assign write_initial_command_word_1   = r_icw1;
   assign write_operation_control_word_1 = r_ocw1;
   assign write_operation_control_word_2 = r_ocw2;
   assign write_operation_control_word_3 = r_ocw3;
   assign read                           = ~chip_select_n & ~read_enable_n & write_enable_n;
   assign interrupt_request              = r_irr;
   assign isr                            = r_isr;

endmodule

// File: tb/tb_pic_bus_irr_isr.sv
// Testbench for pic_bus_irr_isr: directed scenarios plus random traffic.
// The driver pushes the expected visible state for each cycle into a queue;
// a monitor pops and compares on the falling edge.

module tb_pic_bus_irr_isr;

   logic       clk;
   logic       reset_n;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] data;
   logic       sens;
   logic [7:0] ir;
   logic [7:0] clr;
   logic [7:0] int_no;
   logic       eoi;

   logic [7:0] dbus;
   logic       p_icw1;
   logic       p_ocw1;
   logic       p_ocw2;
   logic       p_ocw3;
   logic       rd;
   logic [7:0] irr;
   logic [7:0] isr;

   pic_bus_irr_isr dut (
      .clk                            (clk),
      .reset_n                        (reset_n),
      .chip_select_n                  (cs_n),
      .read_enable_n                  (rd_n),
      .write_enable_n                 (wr_n),
      .A0                             (a0),
      .data_bus_in                    (data),
      .sensitivity_mode               (sens),
      .peripheral_interrupts          (ir),
      .clear_interrupt_request        (clr),
      .int_no                         (int_no),
      .eoi                            (eoi),
      .internal_data_bus              (dbus),
      .write_initial_command_word_1   (p_icw1),
      .write_operation_control_word_1 (p_ocw1),
      .write_operation_control_word_2 (p_ocw2),
      .write_operation_control_word_3 (p_ocw3),
      .read                           (rd),
      .interrupt_request              (irr),
      .isr                            (isr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] dbus;
      logic [3:0] pulse;   // {ocw3, ocw2, ocw1, icw1}
      logic [7:0] irr;
      logic [7:0] isr;
      logic       rd;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: what is visible after the most recent edge.
   logic [7:0] m_dbus;
   logic [3:0] m_pulse;
   logic [7:0] m_irr;
   logic [7:0] m_isr;
   logic [7:0] m_prev;
   logic       m_a0;
   logic       m_in_write;   // bus was in a write last cycle
   logic       m_idle_seen;  // last cycle was idle and out of reset
   logic       m_valid_wr;   // current write started cleanly

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_dbus = 8'h00; m_pulse = 4'h0; m_irr = 8'h00; m_isr = 8'h00;
      m_prev = 8'hFF; m_a0 = 1'b0; m_in_write = 1'b0; m_idle_seen = 1'b0;
      m_valid_wr = 1'b0;
   endtask

   task automatic model_advance();
      bit         wa;
      bit         ended;
      bit         found;
      logic [3:0] np;
      wa    = !cs_n && !wr_n;
      ended = m_in_write && !wa && m_valid_wr;
      np    = 4'h0;
      if (ended) begin
         if (m_a0)           np = 4'b0010;
         else if (m_dbus[4]) np = 4'b0001;
         else if (m_dbus[3]) np = 4'b1000;
         else                np = 4'b0100;
      end
      if (m_pulse[0]) begin
         m_irr = 8'h00; m_isr = 8'h00; m_prev = 8'hFF;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (clr[i])                   m_irr[i] = 1'b0;
            else if (sens)                m_irr[i] = ir[i];
            else if (ir[i] && !m_prev[i]) m_irr[i] = 1'b1;
         end
         found = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (eoi && !found && m_isr[i]) begin
               m_isr[i] = 1'b0;
               found    = 1'b1;
            end
         end
         m_isr  = m_isr | int_no;
         m_prev = ir;
      end
      if (ended)                   m_valid_wr = 1'b0;
      else if (wa && m_idle_seen)  m_valid_wr = 1'b1;
      if (wa) begin
         m_dbus = data;
         m_a0   = a0;
      end
      m_in_write  = wa;
      m_idle_seen = !wa;
      m_pulse     = np;
   endtask

   // Called just after a rising edge with new inputs applied: queues what the
   // monitor should see at the coming falling edge, then crosses one edge.
   task automatic step();
      exp_t e;
      if (!reset_n) model_reset();
      e.dbus  = m_dbus;
      e.pulse = m_pulse;
      e.irr   = m_irr;
      e.isr   = m_isr;
      e.rd    = !cs_n && !rd_n && wr_n;
      sb.push_back(e);
      if (reset_n) model_advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_dbus",  dbus, e.dbus);
            chk("sb_pulse", {4'h0, p_ocw3, p_ocw2, p_ocw1, p_icw1}, {4'h0, e.pulse});
            chk("sb_irr",   irr,  e.irr);
            chk("sb_isr",   isr,  e.isr);
            chk("sb_read",  {7'h0, rd}, {7'h0, e.rd});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] pulses();
      return {4'h0, p_ocw3, p_ocw2, p_ocw1, p_icw1};
   endfunction

   task automatic do_write(input logic wa0, input logic [7:0] d, input int n);
      a0 = wa0; data = d; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
      repeat (n) step();
      cs_n = 1'b1; wr_n = 1'b1;
      step();
   endtask

   task automatic rand_side();
      if ($urandom_range(0, 2) == 0) ir = 8'($urandom);
      clr    = ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      int_no = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      eoi    = ($urandom_range(0, 5) == 0);
   endtask

   initial begin
      reset_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0;
      data = 8'h00; sens = 1'b0; ir = 8'h00; clr = 8'h00; int_no = 8'h00; eoi = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      step();
      step();
      chk("rst_irr", irr, 8'h00);
      chk("rst_isr", isr, 8'h00);
      chk("rst_dbus", dbus, 8'h00);
      chk("rst_pulse", pulses(), 8'h00);
      reset_n = 1'b1;
      step();
      step();

      // ICW1 wipes a non-empty ISR
      int_no = 8'h04; step(); int_no = 8'h00;
      chk("pre_icw1_isr", isr, 8'h04);
      do_write(1'b0, 8'h13, 2);
      chk("icw1_pulse", pulses(), 8'h01);
      chk("icw1_dbus", dbus, 8'h13);
      step();
      chk("icw1_single", pulses(), 8'h00);
      chk("icw1_irr", irr, 8'h00);
      chk("icw1_isr", isr, 8'h00);

      do_write(1'b1, 8'hA5, 2);
      chk("ocw1_pulse", pulses(), 8'h02);
      step();
      chk("ocw1_single", pulses(), 8'h00);
      do_write(1'b0, 8'h0B, 1);
      chk("ocw3_pulse", pulses(), 8'h08);
      step();
      chk("ocw3_single", pulses(), 8'h00);
      do_write(1'b0, 8'h18, 1);
      chk("d11_icw1_only", pulses(), 8'h01);
      step();

      cs_n = 1'b0; rd_n = 1'b0; #1;
      chk("read_hi", {7'h0, rd}, 8'h01);
      step();
      rd_n = 1'b1; #1;
      chk("read_lo_rd", {7'h0, rd}, 8'h00);
      cs_n = 1'b1; step();

      // edge mode
      sens = 1'b0; ir = 8'h00; step();
      ir = 8'h24; step();
      chk("edge_set", irr, 8'h24);
      ir = 8'h00; step();
      chk("edge_hold", irr, 8'h24);
      clr = 8'h04; step(); clr = 8'h00;
      chk("edge_clr", irr, 8'h20);
      step();

      // level mode
      sens = 1'b1; ir = 8'h08; step();
      chk("lvl_set", irr, 8'h08);
      ir = 8'h00; step();
      chk("lvl_drop", irr, 8'h00);
      ir = 8'h08; step();
      clr = 8'h08; step(); clr = 8'h00;
      chk("lvl_clr", irr, 8'h00);
      step();
      chk("lvl_reset", irr, 8'h08);

      // ISR sequence
      int_no = 8'h10; step();
      chk("isr_10", isr, 8'h10);
      int_no = 8'h02; step();
      chk("isr_12", isr, 8'h12);
      int_no = 8'h00; eoi = 1'b1; step();
      chk("isr_eoi", isr, 8'h10);
      int_no = 8'h01; step();
      chk("isr_eoi_set", isr, 8'h01);
      int_no = 8'h00; eoi = 1'b1; step();
      eoi = 1'b1; step();
      chk("isr_eoi_empty", isr, 8'h00);
      eoi = 1'b0;

      // asynchronous reset mid-operation
      ir = 8'hFF; int_no = 8'h81; step(); int_no = 8'h00;
      chk("pre_rst_irr", irr, 8'hFF);
      chk("pre_rst_isr", isr, 8'h81);
      reset_n = 1'b0; #1;
      chk("async_rst_irr", irr, 8'h00);
      chk("async_rst_isr", isr, 8'h00);
      step();
      reset_n = 1'b1; ir = 8'h00; sens = 1'b0; step();

      // reset during a write: that write yields nothing, the next one decodes
      a0 = 1'b1; data = 8'hA5; cs_n = 1'b0; wr_n = 1'b0; step();
      reset_n = 1'b0; step();
      reset_n = 1'b1; step();
      cs_n = 1'b1; wr_n = 1'b1; step();
      chk("rst_wr_nopulse", pulses(), 8'h00);
      step();
      chk("rst_wr_nopulse2", pulses(), 8'h00);
      do_write(1'b0, 8'h00, 2);
      chk("rst_wr_resume", pulses(), 8'h04);
      step();

      // random traffic against the model
      for (int k = 0; k < 2500; k++) begin
         int op;
         if (k % 300 == 0) sens = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 9);
         rand_side();
         if (op < 3) begin
            int n;
            n = $urandom_range(1, 3);
            a0 = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if (!a0 && $urandom_range(0, 7) != 0) data[4] = 1'b0;
            cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
            repeat (n) begin
               rand_side();
               step();
            end
            cs_n = 1'b1; wr_n = 1'b1;
         end else if (op == 3) begin
            cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
         end else begin
            cs_n = 1'($urandom_range(0, 1)); rd_n = 1'b1; wr_n = 1'b1;
         end
         step();
         cs_n = 1'b1; rd_n = 1'b1;
      end

      clr = 8'h00; int_no = 8'h00; eoi = 1'b0;
      step();
      step();
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 8'(sb.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
